// File: rtl/grf_pkg.sv
// Shared types and widths for the GRF writeback arbiter slice.
// Pulled in by grf_scoreboard and grf_wb_arbiter through import grf_pkg::*.
package grf_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_STARVE = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Busy scoreboard for GRF destinations reserved by long-latency issues.
// Register $0 is never marked busy, and a set beats a clear on the same index.
module grf_scoreboard
  import grf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  input  logic [REG_AW-1:0] rd_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_c
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en) w_set_mask[set_idx] = 1'b1;
    if (clr_en) w_clr_mask[clr_idx] = 1'b1;
    w_set_mask[0] = 1'b0;
  end

  // The set mask is ORed in after the clear so a fresh reservation survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign busy_a = r_busy[rd_a];
  assign busy_b = r_busy[rd_b];
  assign busy_c = r_busy[rd_c];

endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between W-stage writeback and the LLU result buffer.
// Optional commit/starve trace printing is enabled by defining GRF_WB_TRACE_EN.
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_wa,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic [DATA_W-1:0] pipe_pc,
  input  logic              llu_valid,
  input  logic [REG_AW-1:0] llu_wa,
  input  logic [DATA_W-1:0] llu_wd,
  input  logic [DATA_W-1:0] llu_pc,
  output logic              llu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_wa,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              hazard,
  output logic              starve_stall,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] PC
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  wb_entry_t        r_buf;

  logic w_full;
  logic w_buf_grant;
  logic w_capture;
  logic w_enter_starve;
  logic w_set_en;
  logic w_busy_rs;
  logic w_busy_rt;
  logic w_busy_iss;

  assign w_full         = (r_state != S_IDLE);
  assign w_buf_grant    = w_full & ~pipe_we;
  assign llu_ready      = ~w_full | w_buf_grant;
  assign w_capture      = llu_valid & llu_ready;
  assign w_enter_starve = (r_state == S_HOLD) & pipe_we & (r_cnt == LIMIT_M1);
  assign starve_stall   = (r_state == S_STARVE);

  // Pipeline writeback always wins; the buffer only drains on a W bubble.
  always_comb begin
    RegWrite = 1'b0;
    WA       = '0;
    WD       = '0;
    PC       = '0;
    if (pipe_we) begin
      RegWrite = 1'b1;
      WA       = pipe_wa;
      WD       = pipe_wd;
      PC       = pipe_pc;
    end else if (w_full) begin
      RegWrite = 1'b1;
      WA       = r_buf.wa;
      WD       = r_buf.wd;
      PC       = r_buf.pc;
    end
  end

  // The counter tracks how many pipe writes have jumped ahead of the buffered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      if (w_capture) begin
        r_buf.wa <= llu_wa;
        r_buf.wd <= llu_wd;
        r_buf.pc <= llu_pc;
      end
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (w_buf_grant) begin
            r_cnt   <= '0;
            r_state <= w_capture ? S_HOLD : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_enter_starve) r_state <= S_STARVE;
          end
        end
        S_STARVE: begin
          if (w_buf_grant) begin
            r_cnt   <= '0;
            r_state <= w_capture ? S_HOLD : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_set_en = iss_valid & ~hazard & (iss_wa != '0);
  assign hazard   = w_busy_rs | w_busy_rt | (iss_valid & w_busy_iss);

  grf_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (w_set_en),
    .set_idx (iss_wa),
    .clr_en  (w_buf_grant),
    .clr_idx (r_buf.wa),
    .rd_a    (rs),
    .rd_b    (rt),
    .rd_c    (iss_wa),
    .busy_a  (w_busy_rs),
    .busy_b  (w_busy_rt),
    .busy_c  (w_busy_iss)
  );

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && RegWrite && (WA != '0)) $display("%d@%h: $%d <= %h", $time, PC, WA, WD);
    if (reset && w_enter_starve) $display("starve @%h", r_buf.pc);
  end
`endif

endmodule
